// File: rtl/truth_sweep_ctrl.sv
// Truth-table sweep controller: walks a 3-input function unit through all 8
// input vectors, captures each answer and compares the table with a golden value.
module truth_sweep_ctrl #(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] expected,
    output logic       inA,
    output logic       inB,
    output logic       inC,
    input  logic       ans,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic       mismatch,
    output logic [2:0] fail_idx
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t     state;
    logic [2:0] idx;
    logic [3:0] cnt;
    logic [7:0] diff;
    logic [2:0] first_bad;

    // Lowest differing bit wins, so scan from the top down.
    always_comb begin
        diff      = result ^ expected;
        first_bad = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (diff[i]) begin
                first_bad = 3'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            idx      <= 3'd0;
            cnt      <= 4'd0;
            inA      <= 1'b0;
            inB      <= 1'b0;
            inC      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= 8'd0;
            mismatch <= 1'b0;
            fail_idx <= 3'd0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        state           <= ST_SETTLE;
                        idx             <= 3'd0;
                        cnt             <= 4'd0;
                        {inA, inB, inC} <= 3'b000;
                        result          <= 8'd0;
                        busy            <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 4'd1;
                        if (cnt == SETTLE_LAST) begin
                            state <= ST_SAMPLE;
                        end
                    end
                end
                ST_SAMPLE: begin
                    // Abort beats the capture: the current bit is left untouched.
                    if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        result[idx] <= ans;
                        if (idx == 3'd7) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            idx             <= idx + 3'd1;
                            {inA, inB, inC} <= idx + 3'd1;
                            cnt             <= 4'd0;
                            state           <= ST_SETTLE;
                        end
                    end
                end
                ST_DONE: begin
                    mismatch <= |diff;
                    fail_idx <= first_bad;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
